uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter. It replaces the fixed 8N1, single-byte-buffered emitter used for status and score output. It adds:
- configurable data width, parity and stop bits;
- a rounded integer baud divisor;
- an internal FIFO, so producers can burst several characters while frames go out back-to-back.

It sits between an on-chip byte producer (valid/ready) and the board TX pin.

## Interface

Parameters
- `clk_freq_hz`, 12000000: system clock frequency in Hz.
- `baud_rate`, 115200: line rate in baud.
- `data_bits`, 8: data bits per frame; legal range 5..8.
- `parity`, 0: 0 = none, 1 = odd, 2 = even.
- `stop_bits`, 1: 1 or 2.
- `fifo_depth`, 4: FIFO entries; power of two, at least 2.

Ports
- `i_clk`  in  1: the single clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_data`  in  `data_bits`: character to send.
- `i_valid`  in  1: `i_data` is valid this cycle.
- `o_ready`  out  1: FIFO can accept a character; equals "not full".
- `o_uart_tx`  out  1: serial line, idle high.
- `o_busy`  out  1: a frame is on the line or the FIFO is non-empty.
- `o_fifo_level`  out  `$clog2(fifo_depth)+1`: number of entries currently in the FIFO.

Reset is synchronous and active-high. `i_clk` is the only clock.

## Operation

- Baud divisor: `DIV = (clk_freq_hz + baud_rate/2) / baud_rate`, computed at elaboration. `DIV` must be at least 2; elaboration fails otherwise. Every line bit lasts exactly `DIV` cycles.
- Push: accepted when `i_valid & o_ready` at a rising edge. `o_ready` derives only from the registered level, never from a same-cycle pop. When full, the push is dropped even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-empty, non-full FIFO: level unchanged, data order preserved (FIFO order).
- Frame, LSB-first:
  - start bit (0);
  - `data_bits` data bits;
  - optional parity bit: odd means the XOR of the data bits plus the parity bit is 1; even means it is 0;
  - `stop_bits` stop bits (1).
- Frame length: `1 + data_bits + (parity!=0) + stop_bits` bit periods.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop and go to START.
  - START: go to DATA after `DIV` cycles.
  - DATA: bit index counts 0..`data_bits`-1. After the last bit, go to PARITY if `parity != 0`, else STOP.
  - PARITY: go to STOP after `DIV` cycles.
  - STOP: lasts `stop_bits*DIV` cycles. On its final cycle, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- Popped data goes into a shift register; parity is computed from the popped word, not accumulated serially.
- `o_uart_tx` is registered. It is 1 in IDLE and STOP, and otherwise drives the current bit.
- Illegal `parity` values (3) behave as none.

## Timing

- Reset values: `o_uart_tx`=1, `o_ready`=1, `o_busy`=0, `o_fifo_level`=0. FSM in IDLE, FIFO pointers 0, baud counter 0.
- Reset asserted mid-frame:
  - line is high on the cycle after the reset edge;
  - FIFO is flushed;
  - no partial frame resumes after reset.
- Push latency: a push at edge t is reflected in `o_fifo_level` after edge t.
- Start latency from idle and an empty FIFO:
  - push at edge t;
  - FSM pops at edge t+1;
  - `o_uart_tx` goes low after edge t+2 and stays low for `DIV` cycles.
- Back-to-back: the start bit of frame n+1 immediately follows the last stop cycle of frame n, with zero idle cycles.
- `o_busy` falls the cycle the FSM enters IDLE with an empty FIFO. It rises the cycle after a push into an idle, empty block.
- Level arithmetic never wraps. The width holds `fifo_depth` exactly.

## Test plan

- 8N1, clk 16, baud 4 (`DIV`=4), push 0xA5 once. Expect:
  - line low 4 cycles;
  - then bits 1,0,1,0,0,1,0,1, 4 cycles each;
  - then high 4 cycles;
  - `o_busy` drops after the stop bit;
  - total 40 cycles low-to-idle.
- 7E2, `DIV`=4, push 0x55, which has four 1s in its 7 bits. Expect:
  - parity bit 0;
  - two stop bits, 8 cycles high;
  - frame length 44 cycles.
- 8O1, push 0x00. Expect:
  - parity bit 1;
  - 11-bit frame.
- Burst of 6 pushes, `fifo_depth`=4, `i_valid` held high. Expect:
  - `o_ready` drops when the level reaches 4;
  - pushes while full are dropped;
  - transmitted frames appear back-to-back with no idle cycles;
  - FIFO order is preserved.
- Push while full on the same cycle as a pop. Expect the push to be rejected and the level to go 4→3.
- Assert `i_rst` in the middle of data bit 3 with 2 entries queued. Expect:
  - line high the next cycle;
  - `o_fifo_level`=0, `o_ready`=1, `o_busy`=0;
  - no further frames until a new push.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small FIFO, frames sent back-to-back
module uart_tx_fifo #(
   parameter int clk_freq_hz = 12000000,
   parameter int baud_rate   = 115200,
   parameter int data_bits   = 8,
   parameter int parity      = 0,
   parameter int stop_bits   = 1,
   parameter int fifo_depth  = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [data_bits-1:0]        i_data,
   input  logic                        i_valid,
   output logic                        o_ready,
   output logic                        o_uart_tx,
   output logic                        o_busy,
   output logic [$clog2(fifo_depth):0] o_fifo_level
);
   localparam int DIV = (clk_freq_hz + baud_rate / 2) / baud_rate;
   localparam int CW = $clog2(DIV);
   localparam int AW = $clog2(fifo_depth);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [2:0] DATA_LAST = 3'(data_bits - 1);
   localparam logic [2:0] STOP_LAST = 3'(stop_bits - 1);
   localparam logic [AW:0] FULL = (AW + 1)'(fifo_depth);
   localparam logic HAS_PAR = (parity == 1) || (parity == 2);

   if (DIV < 2 || data_bits < 5 || data_bits > 8 || stop_bits < 1 || stop_bits > 2 ||
       fifo_depth < 2 || (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_params
      $error("uart_tx_fifo: illegal parameters (divisor below 2 or out-of-range widths)");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state;
   logic [data_bits-1:0] mem [fifo_depth];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          level;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [data_bits-1:0] shreg;
   logic                 par_bit;
   logic                 push, pop, bit_end;
   logic [data_bits-1:0] head;

   assign o_ready      = level != FULL;
   assign o_fifo_level = level;
   assign o_busy       = (state != IDLE) || (level != '0);
   assign push         = i_valid & o_ready;
   assign bit_end      = cnt == DIV_LAST;
   assign head         = mem[rd_ptr];
   assign pop          = (level != '0) &&
                         (state == IDLE || (state == STOP && bit_end && bit_idx == STOP_LAST));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= i_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         level <= level + (AW + 1)'(push) - (AW + 1)'(pop);
      end
   end

   // the line register follows the state by one cycle, so every bit still spans DIV cycles
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         o_uart_tx <= 1'b1;
      end else begin
         o_uart_tx <= (state == START) ? 1'b0 : (state == DATA) ? shreg[0] :
                      (state == PARITY) ? par_bit : 1'b1;
         cnt <= (bit_end || state == IDLE) ? '0 : cnt + CW'(1);
         if (pop) begin
            shreg   <= head;
            par_bit <= (parity == 1) ? ~^head : ^head;
         end
         case (state)
            IDLE:   if (pop) state <= START;
            START:  if (bit_end) state <= DATA;
            DATA:   if (bit_end) begin
               shreg   <= shreg >> 1;
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == DATA_LAST) begin
                  state   <= HAS_PAR ? PARITY : STOP;
                  bit_idx <= '0;
               end
            end
            PARITY: if (bit_end) state <= STOP;
            STOP:   if (bit_end) begin
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == STOP_LAST) begin
                  state   <= pop ? START : IDLE;
                  bit_idx <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
